// File: rtl/knn_select.sv
// Streaming top-K selector: keeps the K nearest (distance, label) pairs of a batch
// in a sorted register list, then drains them nearest-first over a valid/ready stream.
module knn_select #(
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned K       = 4,
  parameter  int unsigned LABEL_W = 8,
  localparam int unsigned DIST_W  = 2 * DATA_W,
  localparam int unsigned IDX_W   = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIST_W-1:0]  in_dist,
  input  logic [LABEL_W-1:0] in_label,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIST_W-1:0]  out_dist,
  output logic [LABEL_W-1:0] out_label,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last
);

  localparam int unsigned CNT_W = $clog2(K + 1);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               valid_q [K];
  logic               valid_d [K];
  logic [DIST_W-1:0]  dist_q  [K];
  logic [DIST_W-1:0]  dist_d  [K];
  logic [LABEL_W-1:0] label_q [K];
  logic [LABEL_W-1:0] label_d [K];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   pos;

  // Outputs are decoded purely from registered state
  assign in_ready  = (state_q == S_FILL);
  assign out_valid = (state_q == S_DRAIN);
  assign out_idx   = idx_q;
  assign out_dist  = out_valid ? dist_q[idx_q]  : '0;
  assign out_label = out_valid ? label_q[idx_q] : '0;
  assign out_last  = out_valid && (CNT_W'(idx_q) == (cnt_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < K; i++) begin
        valid_q[i] <= 1'b0;
        dist_q[i]  <= '0;
        label_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      for (int i = 0; i < K; i++) begin
        valid_q[i] <= valid_d[i];
        dist_q[i]  <= dist_d[i];
        label_q[i] <= label_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    dist_d  = dist_q;
    label_d = label_q;
    pos     = '0;

    // Slots are sorted and contiguous, so the <= matches form a prefix; count it
    for (int i = 0; i < K; i++) begin
      if (valid_q[i] && (dist_q[i] <= in_dist)) begin
        pos = pos + CNT_W'(1);
      end
    end

    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          if (pos < CNT_W'(K)) begin
            for (int i = 1; i < K; i++) begin
              if (CNT_W'(i) > pos) begin
                valid_d[i] = valid_q[i-1];
                dist_d[i]  = dist_q[i-1];
                label_d[i] = label_q[i-1];
              end
            end
            for (int i = 0; i < K; i++) begin
              if (CNT_W'(i) == pos) begin
                valid_d[i] = 1'b1;
                dist_d[i]  = in_dist;
                label_d[i] = in_label;
              end
            end
          end
          if (cnt_q != CNT_W'(K)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (in_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = S_FILL;
            cnt_d   = '0;
            idx_d   = '0;
            for (int i = 0; i < K; i++) begin
              valid_d[i] = 1'b0;
              dist_d[i]  = '0;
              label_d[i] = '0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

endmodule

// File: tb/tb_knn_select.sv
// Directed self-checking bench for knn_select (K=4) with hand-computed drain sequences.
module tb_knn_select;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned K       = 4;
  localparam int unsigned LABEL_W = 8;
  localparam int unsigned DIST_W  = 2 * DATA_W;
  localparam int unsigned IDX_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DIST_W-1:0]  in_dist;
  logic [LABEL_W-1:0] in_label;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [DIST_W-1:0]  out_dist;
  logic [LABEL_W-1:0] out_label;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;

  int total = 0;
  int bad   = 0;

  logic [DIST_W-1:0]  exp_d [8];
  logic [LABEL_W-1:0] exp_l [8];

  knn_select #(.DATA_W(DATA_W), .K(K), .LABEL_W(LABEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dist   (in_dist),
    .in_label  (in_label),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dist  (out_dist),
    .out_label (out_label),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DIST_W-1:0] d, input logic [LABEL_W-1:0] l, input logic last);
    in_valid = 1'b1;
    in_dist  = d;
    in_label = l;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  64'(in_ready),  64'd1);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".out_dist"},  64'(out_dist),  64'd0);
    check({tag, ".out_label"}, 64'(out_label), 64'd0);
    check({tag, ".out_idx"},   64'(out_idx),   64'd0);
    check({tag, ".out_last"},  64'(out_last),  64'd0);
  endtask

  task automatic check_entry(input string tag, input int i, input int n);
    check({tag, ".valid"},    64'(out_valid), 64'd1);
    check({tag, ".in_ready"}, 64'(in_ready),  64'd0);
    check({tag, ".dist"},     64'(out_dist),  64'(exp_d[i]));
    check({tag, ".label"},    64'(out_label), 64'(exp_l[i]));
    check({tag, ".idx"},      64'(out_idx),   64'(i));
    check({tag, ".last"},     64'(out_last),  64'(i == n - 1));
  endtask

  // Drain n expected entries; optionally stall 3 cycles at rank stall_at
  task automatic drain(input string tag, input int n, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check_entry({tag, ".stall"}, i, n);
          in_valid = 1'b1;
          in_dist  = 32'd1;
          in_label = 8'hEE;
          in_last  = 1'b1;
          tick();
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      out_ready = 1'b1;
      check_entry(tag, i, n);
      tick();
    end
    out_ready = 1'b0;
    check({tag, ".post_in_ready"},  64'(in_ready),  64'd1);
    check({tag, ".post_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_dist = '0; in_label = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b1;

    // Basic ranking
    send(32'd50, 8'd1, 1'b0); send(32'd10, 8'd2, 1'b0); send(32'd30, 8'd3, 1'b0);
    send(32'd20, 8'd4, 1'b0); send(32'd40, 8'd5, 1'b1);
    exp_d[0] = 32'd10; exp_l[0] = 8'd2; exp_d[1] = 32'd20; exp_l[1] = 8'd4;
    exp_d[2] = 32'd30; exp_l[2] = 8'd3; exp_d[3] = 32'd40; exp_l[3] = 8'd5;
    drain("basic", 4, -1);

    // Same batch with backpressure at rank 1; ignored in_valid pulses must not appear
    send(32'd50, 8'd1, 1'b0); send(32'd10, 8'd2, 1'b0); send(32'd30, 8'd3, 1'b0);
    send(32'd20, 8'd4, 1'b0); send(32'd40, 8'd5, 1'b1);
    drain("bp", 4, 1);

    // Short batch
    send(32'd7, 8'h0A, 1'b0); send(32'd3, 8'h0B, 1'b1);
    exp_d[0] = 32'd3; exp_l[0] = 8'h0B; exp_d[1] = 32'd7; exp_l[1] = 8'h0A;
    drain("short", 2, -1);

    // Ties keep arrival order
    for (int i = 1; i <= 5; i++) send(32'd5, 8'(i), 1'(i == 5));
    for (int i = 0; i < 4; i++) begin exp_d[i] = 32'd5; exp_l[i] = 8'(i + 1); end
    drain("ties", 4, -1);

    // All-ones distance stored when a slot is free
    send(32'hFFFF_FFFF, 8'd9, 1'b1);
    exp_d[0] = 32'hFFFF_FFFF; exp_l[0] = 8'd9;
    drain("maxval", 1, -1);

    // All-ones distance dropped when the list is full of smaller entries
    send(32'd4, 8'd1, 1'b0); send(32'd3, 8'd2, 1'b0); send(32'd2, 8'd3, 1'b0);
    send(32'd1, 8'd4, 1'b0); send(32'hFFFF_FFFF, 8'd9, 1'b1);
    for (int i = 0; i < 4; i++) begin exp_d[i] = 32'(i + 1); exp_l[i] = 8'(4 - i); end
    drain("maxdrop", 4, -1);

    // Reset mid-fill
    send(32'd11, 8'd1, 1'b0); send(32'd12, 8'd2, 1'b0); send(32'd13, 8'd3, 1'b0);
    rst = 1'b0; tick(); rst = 1'b1;
    check_reset_outputs("rst_fill");

    // Reset mid-drain at rank 2
    send(32'd21, 8'd1, 1'b0); send(32'd22, 8'd2, 1'b0); send(32'd23, 8'd3, 1'b0);
    send(32'd24, 8'd4, 1'b1);
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
    check("rst_drain.pre_idx", 64'(out_idx), 64'd2);
    rst = 1'b0; tick(); rst = 1'b1;
    check_reset_outputs("rst_drain");

    send(32'd8, 8'd1, 1'b0); send(32'd6, 8'd2, 1'b1);
    exp_d[0] = 32'd6; exp_l[0] = 8'd2; exp_d[1] = 32'd8; exp_l[1] = 8'd1;
    drain("post_rst", 2, -1);

    // Back-to-back: in_valid held high across the batch boundary
    in_valid = 1'b1; in_dist = 32'd9; in_label = 8'd1; in_last = 1'b0; tick();
    in_dist = 32'd4; in_label = 8'd2; in_last = 1'b1; tick();
    in_dist = 32'd100; in_label = 8'd7; in_last = 1'b0;
    exp_d[0] = 32'd4; exp_l[0] = 8'd2; exp_d[1] = 32'd9; exp_l[1] = 8'd1;
    drain("b2b_a", 2, -1);
    tick();
    in_dist = 32'd50; in_label = 8'd8; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    exp_d[0] = 32'd50; exp_l[0] = 8'd8; exp_d[1] = 32'd100; exp_l[1] = 8'd7;
    drain("b2b_b", 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/knn_select.md
# knn_select

Streaming top-K selector that consumes (distance, label) pairs from the KNN distance datapath and keeps the K smallest distances in a sorted register list. At the end of a batch it drains that list, nearest first, over a valid/ready output stream to the classification/vote stage or the CPU-side FIFO. It pairs with the distance core: that block produces distances, and this block receives and ranks them.

## Interface
- DATA_W, 16: coordinate width. Distances are 2*DATA_W bits wide.
- K, 4: number of neighbours kept. Legal range 1..16.
- LABEL_W, 8: width of the class label.
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-low. Sampled on the rising edge of clk.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block accepts input.
- in_dist  in  2*DATA_W  unsigned distance.
- in_label  in  LABEL_W  label of the training point.
- in_last  in  1  marks the final pair of the batch.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_dist  out  2*DATA_W  distance of the current rank.
- out_label  out  LABEL_W  label of the current rank.
- out_idx  out  clog2(K) (minimum 1)  rank, where 0 is the nearest.
- out_last  out  1  high on the final drained entry.

## Operation
- The list has K slots, each holding {valid, dist, label}, sorted ascending. Valid slots are always contiguous from slot 0.
- Two states: FILL and DRAIN.
- **FILL**
  - in_ready=1, out_valid=0.
  - On an accepted pair, compute pos = number of valid slots with dist <= in_dist. Compare unsigned, full 2*DATA_W bits.
  - If pos < K: slots pos..K-2 shift to pos+1..K-1, slot K-1 is discarded, and the new pair is written at pos with valid=1.
  - If pos == K: the pair is dropped and the list is unchanged.
  - Ties keep arrival order: an earlier equal distance ranks nearer.
  - The all-ones distance is an ordinary value. It is stored if a slot is free and dropped if the list is full of entries with dist <= it.
  - cnt = number of valid slots, saturating at K.
  - If in_last is set on the accepted pair, insert it first, then go to DRAIN.
- **DRAIN**
  - in_ready=0.
  - out_valid=1, out_dist/out_label = slot[idx], out_idx=idx, out_last=(idx==cnt-1).
  - On each out_valid & out_ready, idx increments.
  - On the out_last handshake, all slots are cleared (valid=0), cnt=0, idx=0, and the state goes to FILL.
  - Exactly min(points received, K) entries are drained. A batch always has at least 1 point, because in_last travels with a pair.
- in_valid with in_ready=0 is ignored. No pair is buffered in DRAIN.
- Reset (rst=0 at an edge), from any state including mid-FILL or mid-DRAIN:
  - state=FILL, all slots invalid with dist=0 and label=0, cnt=0, idx=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_dist=0, out_label=0, out_idx=0, out_last=0.
  - A partial batch is discarded.

## Timing
- Input throughput: 1 pair per cycle in FILL. Insert compare and shift completes in one cycle, with the comparators running in parallel.
- A pair accepted at edge t is visible in the list from t+1.
- If that pair carries in_last: DRAIN starts at t+1, out_valid=1 from t+1, and rank 0 already includes the last pair.
- Output: 1 entry per cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, out_dist, out_label, out_idx and out_last stay stable.
  - out_valid never drops before its handshake.
- After the out_last handshake at edge u: in_ready=1 and out_valid=0 from u+1.
- All outputs are registered or decoded from registered state. There is no combinational path from in_* to out_*. in_ready does not depend on in_valid.

## Test plan
- **Basic ranking** (K=4): dists 50,10,30,20,40 with labels 1..5, last on the fifth pair.
  - Required output: (10,2,idx0), (20,4,idx1), (30,3,idx2), (40,5,idx3).
  - out_last only on idx3. in_ready=1 on the cycle after the final handshake.
- **Short batch**: dists 7,3 with labels 0xA,0xB, last on the second pair.
  - Required output: exactly 2 entries, (3,0xB,idx0) then (7,0xA,idx1,out_last=1).
- **Ties and max value**:
  - Five pairs, all dist=5, labels 1..5: drained labels are 1,2,3,4.
  - Separate batch, single pair dist=0xFFFFFFFF, label 9, last: one entry (0xFFFFFFFF,9,idx0,out_last=1).
- **Backpressure**: during the drain of the basic-ranking batch, hold out_ready=0 for 3 cycles at idx1.
  - Required: out_dist=20, out_label=4, idx=1 stable for all 3 cycles; in_ready=0 throughout; in_valid pulses are ignored.
- **Reset mid-operation**:
  - Assert rst=0 for 1 cycle after 3 pairs in FILL. Required: all outputs at reset values.
  - Then assert rst=0 for 1 cycle at idx2 of a drain. Same requirement.
  - A following batch 8,6 (last) drains exactly (6),(8), with no stale entries.
- **Back-to-back batches**: in_valid held at 1 across the boundary.
  - The first pair of the next batch is accepted only after the out_last handshake.
  - Its drain reflects only new data.
